// File: rtl/hbridge_guard.sv
// hbridge_guard: per-motor H-bridge protection stage. Registers controller
// commands, enforces dead-time on stop/reversal, rejects F=B=1 commands and
// latches filtered overcurrent faults with a timed retry. Channel 0 is the
// right motor, channel 1 the left; only the fault counter/flag are shared.
module hbridge_guard #(
    parameter int unsigned DEAD_CYCLES  = 5000,
    parameter int unsigned OC_FILT      = 16,
    parameter int unsigned RETRY_CYCLES = 10000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RMF,
    input  logic       RMB,
    input  logic       LMF,
    input  logic       LMB,
    input  logic       RM_pwm,
    input  logic       LM_pwm,
    input  logic       oc_r,
    input  logic       oc_L,
    output logic       r_in1,
    output logic       r_in2,
    output logic       r_en,
    output logic       l_in1,
    output logic       l_in2,
    output logic       l_en,
    output logic       fault,
    output logic       illegal,
    output logic [3:0] fault_cnt
);

    localparam int unsigned NCH    = 2;
    localparam int unsigned TMR_W  = 24;
    localparam int unsigned OCF_W  = 8;
    localparam int unsigned FCNT_W = 4;

    localparam logic [TMR_W-1:0]  DEAD_LOAD  = TMR_W'(DEAD_CYCLES - 1);
    localparam logic [TMR_W-1:0]  RETRY_LOAD = TMR_W'(RETRY_CYCLES - 1);
    localparam logic [OCF_W-1:0]  OC_LIMIT   = OCF_W'(OC_FILT);
    localparam logic [FCNT_W-1:0] FCNT_MAX   = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN_F,
        ST_RUN_B,
        ST_DEAD,
        ST_FAULT
    } state_e;

    // Raw inputs gathered per channel (index 0 = right, 1 = left)
    logic [NCH-1:0] fwd_raw_c, bwd_raw_c, pwm_raw_c, oc_raw_c;
    assign fwd_raw_c = {LMF, RMF};
    assign bwd_raw_c = {LMB, RMB};
    assign pwm_raw_c = {LM_pwm, RM_pwm};
    assign oc_raw_c  = {oc_L, oc_r};

    logic [NCH-1:0] fwd_q, bwd_q, oc_q;

    // Command decode on the registered samples; 11 decodes as STOP
    logic [NCH-1:0] go_f_c, go_b_c, stop_c, illegal_c;
    assign go_f_c    = fwd_q & ~bwd_q;
    assign go_b_c    = ~fwd_q & bwd_q;
    assign stop_c    = ~(go_f_c | go_b_c);
    assign illegal_c = fwd_q & bwd_q;

    state_e           st_q  [NCH];
    state_e           st_d  [NCH];
    logic [TMR_W-1:0] tmr_q [NCH];
    logic [TMR_W-1:0] tmr_d [NCH];
    logic [OCF_W-1:0] occ_q [NCH];
    logic [OCF_W-1:0] occ_d [NCH];

    logic [NCH-1:0]    enter_c;
    logic [NCH-1:0]    in1_q, in1_d, in2_q, in2_d, en_q, en_d;
    logic              fault_q, fault_d, illegal_q, illegal_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [FCNT_W:0]   fcnt_sum_c;

    // State, counters, input samples and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fwd_q     <= '0;
            bwd_q     <= '0;
            oc_q      <= '0;
            in1_q     <= '0;
            in2_q     <= '0;
            en_q      <= '0;
            fault_q   <= 1'b0;
            illegal_q <= 1'b0;
            fcnt_q    <= '0;
            for (int unsigned c = 0; c < NCH; c++) begin
                st_q[c]  <= ST_IDLE;
                tmr_q[c] <= '0;
                occ_q[c] <= '0;
            end
        end else begin
            fwd_q     <= fwd_raw_c;
            bwd_q     <= bwd_raw_c;
            oc_q      <= oc_raw_c;
            in1_q     <= in1_d;
            in2_q     <= in2_d;
            en_q      <= en_d;
            fault_q   <= fault_d;
            illegal_q <= illegal_d;
            fcnt_q    <= fcnt_d;
            for (int unsigned c = 0; c < NCH; c++) begin
                st_q[c]  <= st_d[c];
                tmr_q[c] <= tmr_d[c];
                occ_q[c] <= occ_d[c];
            end
        end
    end

    // Per-channel next state; overcurrent entry overrides every other move
    always_comb begin
        enter_c = '0;
        in1_d   = '0;
        in2_d   = '0;
        en_d    = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            st_d[c]  = st_q[c];
            tmr_d[c] = tmr_q[c];
            occ_d[c] = '0;
            if (oc_q[c]) begin
                occ_d[c] = (occ_q[c] == OC_LIMIT) ? occ_q[c] : occ_q[c] + OCF_W'(1);
            end

            if ((st_q[c] != ST_FAULT) && (occ_d[c] == OC_LIMIT)) begin
                st_d[c]    = ST_FAULT;
                tmr_d[c]   = RETRY_LOAD;
                enter_c[c] = 1'b1;
            end else begin
                case (st_q[c])
                    ST_IDLE: begin
                        if (go_f_c[c])      st_d[c] = ST_RUN_F;
                        else if (go_b_c[c]) st_d[c] = ST_RUN_B;
                    end
                    ST_RUN_F: begin
                        if (!go_f_c[c]) begin
                            st_d[c]  = ST_DEAD;
                            tmr_d[c] = DEAD_LOAD;
                        end
                    end
                    ST_RUN_B: begin
                        if (!go_b_c[c]) begin
                            st_d[c]  = ST_DEAD;
                            tmr_d[c] = DEAD_LOAD;
                        end
                    end
                    ST_DEAD: begin
                        if (tmr_q[c] != '0)  tmr_d[c] = tmr_q[c] - TMR_W'(1);
                        else if (go_f_c[c])  st_d[c]  = ST_RUN_F;
                        else if (go_b_c[c])  st_d[c]  = ST_RUN_B;
                        else                 st_d[c]  = ST_IDLE;
                    end
                    ST_FAULT: begin
                        if (tmr_q[c] != '0)                tmr_d[c] = tmr_q[c] - TMR_W'(1);
                        else if (!oc_q[c] && stop_c[c])    st_d[c]  = ST_IDLE;
                    end
                    default: st_d[c] = ST_IDLE;
                endcase
            end

            in1_d[c] = (st_d[c] == ST_RUN_F);
            in2_d[c] = (st_d[c] == ST_RUN_B);
            en_d[c]  = ((st_d[c] == ST_RUN_F) || (st_d[c] == ST_RUN_B)) && pwm_raw_c[c];
        end

        fault_d    = (st_d[0] == ST_FAULT) || (st_d[1] == ST_FAULT);
        illegal_d  = |illegal_c;
        fcnt_sum_c = {1'b0, fcnt_q} + (FCNT_W+1)'(enter_c[0]) + (FCNT_W+1)'(enter_c[1]);
        fcnt_d     = (fcnt_sum_c > {1'b0, FCNT_MAX}) ? FCNT_MAX : fcnt_sum_c[FCNT_W-1:0];
    end

    assign r_in1     = in1_q[0];
    assign r_in2     = in2_q[0];
    assign r_en      = en_q[0];
    assign l_in1     = in1_q[1];
    assign l_in2     = in2_q[1];
    assign l_en      = en_q[1];
    assign fault     = fault_q;
    assign illegal   = illegal_q;
    assign fault_cnt = fcnt_q;

endmodule

// File: tb/tb_hbridge_guard.sv
// tb_hbridge_guard: directed scenarios plus randomized traffic, every cycle
// compared against a mode/elapsed-time reference model of both channels.
module tb_hbridge_guard;

    localparam int DC = 4;
    localparam int OF = 3;
    localparam int RC = 8;

    localparam int M_IDLE = 0;
    localparam int M_FWD  = 1;
    localparam int M_BWD  = 2;
    localparam int M_DEAD = 3;
    localparam int M_FLT  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic RMF = 0, RMB = 0, LMF = 0, LMB = 0, RM_pwm = 0, LM_pwm = 0, oc_r = 0, oc_L = 0;
    logic r_in1, r_in2, r_en, l_in1, l_in2, l_en, fault, illegal;
    logic [3:0] fault_cnt;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;

    hbridge_guard #(.DEAD_CYCLES(DC), .OC_FILT(OF), .RETRY_CYCLES(RC)) dut (
        .clk(clk), .rst_n(rst_n),
        .RMF(RMF), .RMB(RMB), .LMF(LMF), .LMB(LMB),
        .RM_pwm(RM_pwm), .LM_pwm(LM_pwm), .oc_r(oc_r), .oc_L(oc_L),
        .r_in1(r_in1), .r_in2(r_in2), .r_en(r_en),
        .l_in1(l_in1), .l_in2(l_in2), .l_en(l_en),
        .fault(fault), .illegal(illegal), .fault_cnt(fault_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: mode per channel, cycles spent in it, oc run length
    int m_mode [2];
    int m_el   [2];
    int m_ocr  [2];
    bit s_f [2], s_b [2], s_oc [2];
    bit e_in1 [2], e_in2 [2], e_en [2];
    bit e_fault, e_ill;
    int e_cnt;

    always @(posedge clk) begin : model
        int ent;
        ent = 0;
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                m_mode[c] = M_IDLE; m_el[c] = 0; m_ocr[c] = 0;
                s_f[c] = 0; s_b[c] = 0; s_oc[c] = 0;
                e_in1[c] = 0; e_in2[c] = 0; e_en[c] = 0;
            end
            e_fault = 0; e_ill = 0; e_cnt = 0;
        end else begin
            e_ill = (s_f[0] && s_b[0]) || (s_f[1] && s_b[1]);
            for (int c = 0; c < 2; c++) begin
                bit cf, cb, cp, co;
                int cmd, nm;
                cf = (c == 0) ? RMF : LMF;
                cb = (c == 0) ? RMB : LMB;
                cp = (c == 0) ? RM_pwm : LM_pwm;
                co = (c == 0) ? oc_r : oc_L;
                cmd = (s_f[c] && !s_b[c]) ? 1 : ((!s_f[c] && s_b[c]) ? 2 : 0);
                m_ocr[c] = s_oc[c] ? m_ocr[c] + 1 : 0;
                nm = m_mode[c];
                if (m_mode[c] != M_FLT && m_ocr[c] >= OF) begin
                    nm = M_FLT;
                    ent++;
                end else begin
                    case (m_mode[c])
                        M_IDLE: nm = (cmd == 1) ? M_FWD : ((cmd == 2) ? M_BWD : M_IDLE);
                        M_FWD:  if (cmd != 1) nm = M_DEAD;
                        M_BWD:  if (cmd != 2) nm = M_DEAD;
                        M_DEAD: if (m_el[c] >= DC) nm = (cmd == 1) ? M_FWD : ((cmd == 2) ? M_BWD : M_IDLE);
                        default: if (m_el[c] >= RC && !s_oc[c] && cmd == 0) nm = M_IDLE;
                    endcase
                end
                m_el[c]   = (nm != m_mode[c]) ? 1 : m_el[c] + 1;
                m_mode[c] = nm;
                s_f[c] = cf; s_b[c] = cb; s_oc[c] = co;
                e_in1[c] = (nm == M_FWD);
                e_in2[c] = (nm == M_BWD);
                e_en[c]  = (nm == M_FWD || nm == M_BWD) && cp;
            end
            e_fault = (m_mode[0] == M_FLT) || (m_mode[1] == M_FLT);
            e_cnt   = (e_cnt + ent > 15) ? 15 : e_cnt + ent;
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        logic [12:0] got, exp;
        if (chk_en) begin
            got = {r_in1, r_in2, r_en, l_in1, l_in2, l_en, fault, illegal, fault_cnt};
            exp = {e_in1[0], e_in2[0], e_en[0], e_in1[1], e_in2[1], e_en[1], e_fault, e_ill, 4'(e_cnt)};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL model_cmp t=%0t got=%b expected=%b", $time, got, exp);
            end
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_fault(input bit r, input bit l, output int cnt_ent, output int flt_ent);
        oc_r = r; oc_L = l;
        repeat (3) cyc();
        oc_r = 0; oc_L = 0;
        cyc();
        cnt_ent = int'(fault_cnt);
        flt_ent = int'(fault);
        repeat (11) cyc();
    endtask

    initial begin
        int zeros, ill_n, both_n, fhi, fseen, ce, fe;
        int burst [2];
        logic [1:0] rcmd [2];

        // Reset with a live command
        RMF = 1; RM_pwm = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_en = 1;
            chk("rst_in1", int'(r_in1), 0);
            chk("rst_en", int'(r_en), 0);
        end
        rst_n = 1;
        cyc();
        chk("cmd_lat_edge_k", int'(r_in1), 0);
        cyc();
        chk("cmd_lat_edge_k1", int'(r_in1), 1);
        chk("en_on", int'(r_en), 1);
        RM_pwm = 0; cyc();
        chk("en_follows_pwm0", int'(r_en), 0);
        RM_pwm = 1; cyc();
        chk("en_follows_pwm1", int'(r_en), 1);

        // Reversal: exactly DC dead cycles
        RMF = 0; RMB = 1;
        cyc();
        chk("rev_still_fwd", int'(r_in1), 1);
        zeros = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (r_in2) break;
            if (!r_in1 && !r_in2 && !r_en) zeros++;
        end
        chk("rev_dead_len", zeros, DC);
        chk("rev_in2", int'(r_in2), 1);

        // FWD -> STOP -> FWD glitch inside the dead window
        RMF = 1; RMB = 0;
        zeros = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 1) RMF = 0;
            if (i == 2) RMF = 1;
            cyc();
            if (r_in1) break;
            if (!r_in1 && !r_in2 && !r_en) zeros++;
        end
        chk("glitch_dead_len", zeros, DC);
        chk("glitch_in1", int'(r_in1), 1);

        // Illegal command on the left channel while it runs forward
        LMF = 1; LM_pwm = 1;
        repeat (3) cyc();
        chk("left_run", int'(l_in1), 1);
        LMB = 1;
        ill_n = 0; both_n = 0;
        for (int i = 0; i < 14; i++) begin
            if (i == 2) begin LMF = 0; LMB = 0; end
            cyc();
            ill_n += int'(illegal);
            both_n += int'(l_in1 & l_in2);
        end
        chk("illegal_pulses", ill_n, 2);
        chk("illegal_both_hi", both_n, 0);
        chk("illegal_idle", int'({l_in1, l_in2, l_en}), 0);

        // Overcurrent filter and retry timing on the right channel
        RMF = 0; RMB = 0;
        repeat (8) cyc();
        oc_r = 1; cyc(); cyc(); oc_r = 0;
        fseen = 0;
        for (int i = 0; i < 8; i++) begin cyc(); fseen |= int'(fault); end
        chk("oc_short_nofault", fseen, 0);
        oc_r = 1; repeat (3) cyc(); oc_r = 0;
        fhi = 0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (fault) begin
                if (fhi == 0) chk("oc_first_cnt", int'(fault_cnt), 1);
                fhi++;
            end else if (fhi > 0) break;
        end
        chk("oc_fault_len", fhi, RC);

        // Fault counter saturation
        for (int i = 0; i < 13; i++) do_fault(1, 0, ce, fe);
        chk("cnt_14", int'(fault_cnt), 14);
        do_fault(1, 1, ce, fe);
        chk("dual_from_14", ce, 15);
        chk("dual_fault_flag", fe, 1);
        do_fault(1, 0, ce, fe);
        chk("cnt_sat", ce, 15);

        // Randomized traffic with occasional resets
        burst[0] = 0; burst[1] = 0;
        rcmd[0] = 2'b00; rcmd[1] = 2'b00;
        for (int n = 0; n < 4000; n++) begin
            for (int c = 0; c < 2; c++) begin
                if ($urandom_range(7) == 0) rcmd[c] = 2'($urandom_range(3));
                if (burst[c] > 0) burst[c]--;
                else if ($urandom_range(39) == 0) burst[c] = $urandom_range(5, 1);
            end
            {RMF, RMB} = rcmd[0];
            {LMF, LMB} = rcmd[1];
            RM_pwm = 1'($urandom_range(1));
            LM_pwm = 1'($urandom_range(1));
            oc_r = (burst[0] > 0);
            oc_L = (burst[1] > 0);
            rst_n = ($urandom_range(399) != 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
